// File: rtl/exec_run_controller.sv
// Run/halt/step sequencer: gates PC/commit enable on syscall halts, a PC breakpoint
// and debounced go/step buttons; also drives the display strobe and retired count.

module erc_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d, lvl_prev_q;

  // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing synced sample.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = sync_q[1];
      else                                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign pulse_o = lvl_q & ~lvl_prev_q;
endmodule

module exec_run_controller #(
  parameter int DATA_BITS       = 32,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DISPLAY_CODE    = 34
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_go,
  input  logic                 btn_step,
  input  logic                 syscall,
  input  logic [DATA_BITS-1:0] reg_v0,
  input  logic [DATA_BITS-1:0] pc,
  input  logic                 bp_en,
  input  logic [DATA_BITS-1:0] bp_addr,
  output logic                 pcen,
  output logic                 halted,
  output logic                 display_we,
  output logic [1:0]           halt_cause,
  output logic [DATA_BITS-1:0] retired_cnt
);
  localparam int NUM_BTN = 2;
  localparam logic [1:0] CAUSE_NONE = 2'd0, CAUSE_SYS = 2'd1,
                         CAUSE_BP   = 2'd2, CAUSE_STEP = 2'd3;

  typedef enum logic {RUN, HALT} state_e;

  state_e               state_q, state_d;
  logic [1:0]           cause_q, cause_d;
  logic [DATA_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_BTN-1:0]   btn_raw, btn_p;
  logic                 go_p, step_p, is_display, sys_halt, bp_hit;

  // Bit 0 = go, bit 1 = step; both buttons share identical conditioning.
  assign btn_raw = {btn_step, btn_go};

  erc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_raw),
    .pulse_o (btn_p)
  );

  assign go_p       = btn_p[0];
  assign step_p     = btn_p[1];
  assign is_display = (reg_v0 == DATA_BITS'(DISPLAY_CODE));
  assign sys_halt   = syscall && !is_display;
  assign bp_hit     = bp_en && (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pcen    = 1'b0;
    case (state_q)
      RUN: begin
        if (sys_halt) begin
          state_d = HALT;
          cause_d = CAUSE_SYS;
        end else if (bp_hit) begin
          state_d = HALT;
          cause_d = CAUSE_BP;
        end else begin
          pcen = 1'b1;
        end
      end
      HALT: begin
        // The resume cycle commits the halting instruction without re-checking bp.
        if (go_p) begin
          pcen    = 1'b1;
          state_d = RUN;
          cause_d = CAUSE_NONE;
        end else if (step_p) begin
          pcen    = 1'b1;
          cause_d = CAUSE_STEP;
        end
      end
      default: state_d = RUN;
    endcase
    cnt_d = (pcen && !(&cnt_q)) ? cnt_q + DATA_BITS'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign halt_cause  = cause_q;
  assign retired_cnt = cnt_q;
  assign display_we  = syscall && is_display && pcen;
endmodule

// File: tb/tb_exec_run_controller.sv
// Bench for exec_run_controller: directed scenarios plus randomized run against a
// reference model built from the halt/resume rules and a sample-history button model.

module tb_exec_run_controller;
  localparam int DB = 32;
  localparam int DC = 4;
  localparam int DISP = 34;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_go, btn_step, syscall, bp_en;
  logic [DB-1:0] reg_v0, pc, bp_addr, retired_cnt;
  logic          pcen, halted, display_we;
  logic [1:0]    halt_cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_run_controller #(.DATA_BITS(DB), .DEBOUNCE_CYCLES(DC), .DISPLAY_CODE(DISP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_go(btn_go), .btn_step(btn_step), .syscall(syscall),
    .reg_v0(reg_v0), .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .pcen(pcen),
    .halted(halted), .display_we(display_we), .halt_cause(halt_cause),
    .retired_cnt(retired_cnt)
  );

  // Reference model: run/halt flag, cause, retire count, and per-button raw and
  // synced sample histories; a debounced level flips once the last DC synced
  // samples all disagree with it.
  bit            m_halted;
  bit [1:0]      m_cause;
  logic [DB-1:0] m_cnt;
  logic [15:0]   m_syn [2];
  logic [1:0]    m_raw [2];
  bit            m_db  [2];
  bit            m_dbp [2];

  function automatic void model_reset();
    m_halted = 1'b0; m_cause = 2'd0; m_cnt = '0;
    for (int b = 0; b < 2; b++) begin
      m_syn[b] = '0; m_raw[b] = '0; m_db[b] = 1'b0; m_dbp[b] = 1'b0;
    end
  endfunction

  function automatic void model_comb(output bit pe, output bit nh, output bit [1:0] nc);
    bit gp, sp, sh, bh;
    gp = m_db[0] && !m_dbp[0];
    sp = m_db[1] && !m_dbp[1];
    sh = syscall && (reg_v0 != DISP);
    bh = bp_en && (pc == bp_addr);
    pe = 1'b0; nh = m_halted; nc = m_cause;
    if (!m_halted) begin
      if (sh)      begin nh = 1'b1; nc = 2'd1; end
      else if (bh) begin nh = 1'b1; nc = 2'd2; end
      else         pe = 1'b1;
    end else begin
      if (gp)      begin pe = 1'b1; nh = 1'b0; nc = 2'd0; end
      else if (sp) begin pe = 1'b1; nc = 2'd3; end
    end
  endfunction

  function automatic void model_edge();
    bit pe, nh; bit [1:0] nc; logic fed, cur; logic [15:0] mask;
    model_comb(pe, nh, nc);
    m_halted = nh; m_cause = nc;
    if (pe && m_cnt != '1) m_cnt = m_cnt + 1;
    mask = 16'((1 << DC) - 1);
    for (int b = 0; b < 2; b++) begin
      cur = (b == 0) ? btn_go : btn_step;
      fed = m_raw[b][1];
      m_raw[b] = {m_raw[b][0], cur};
      m_syn[b] = {m_syn[b][14:0], fed};
      m_dbp[b] = m_db[b];
      if (m_db[b]) begin if ((m_syn[b] & mask) == 16'd0) m_db[b] = 1'b0; end
      else         begin if ((m_syn[b] & mask) == mask)  m_db[b] = 1'b1; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    btn_go = 0; btn_step = 0; syscall = 0; bp_en = 0; reg_v0 = '0; pc = '0; bp_addr = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    btn_go = 0; btn_step = 0; syscall = 0; bp_en = 0; reg_v0 = '0; pc = '0; bp_addr = '0;
    #3;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (retired_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retired_cnt); end
    checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", halt_cause); end
    checks++; if (pcen !== 1'b1) begin errors++; $display("FAIL reset_pcen got %0b want 1", pcen); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (pcen !== 1'b1 || halted !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL run_pcen got %0d stalled cycles want 0", bad); end
    checks++; if (retired_cnt !== 32'd10) begin errors++; $display("FAIL run_cnt got %0d want 10", retired_cnt); end
    checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL run_cause got %0d want 0", halt_cause); end
  endtask

  task automatic test_syscall_halt();
    logic [DB-1:0] c0;
    int bad = 0;
    syscall = 1; reg_v0 = 32'd10;
    #1;
    checks++; if (pcen !== 1'b0) begin errors++; $display("FAIL sys_pcen got %0b want 0", pcen); end
    tick(); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL sys_halted got %0b want 1", halted); end
    checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL sys_cause got %0d want 1", halt_cause); end
    c0 = retired_cnt;
    for (int i = 0; i < 20; i++) begin
      #1; if (pcen !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL sys_hold got %0d commit cycles want 0", bad); end
    checks++; if (retired_cnt !== c0) begin errors++; $display("FAIL sys_frozen got %0d want %0d", retired_cnt, c0); end
  endtask

  task automatic test_go_resume();
    int hits = 0, at = -1, bad = 0;
    btn_go = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) syscall = 0;
      #1;
      if (i <= 6 && pcen === 1'b1) begin hits++; at = i; end
      if (i == 7) begin
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL go_run got halted=%0b want 0", halted); end
        checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL go_cause got %0d want 0", halt_cause); end
      end
      tick();
    end
    checks++; if (hits != 1 || at != 2 + DC) begin errors++; $display("FAIL go_pulse got %0d pulses at %0d want 1 at %0d", hits, at, 2 + DC); end
    btn_go = 0; repeat (8) tick();
    syscall = 1; reg_v0 = 32'd10; tick();
    btn_go = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) btn_go = 0;
      #1; if (pcen !== 1'b0 || halted !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL go_glitch got %0d resumed cycles want 0", bad); end
  endtask

  task automatic test_bp_step();
    int hits = 0, at = -1;
    do_reset();
    bp_en = 1; bp_addr = 32'h10; pc = 32'h0C;
    #1;
    checks++; if (pcen !== 1'b1) begin errors++; $display("FAIL bp_before got %0b want 1", pcen); end
    tick(); pc = 32'h10; #1;
    checks++; if (pcen !== 1'b0) begin errors++; $display("FAIL bp_pcen got %0b want 0", pcen); end
    tick(); #1;
    checks++; if (halted !== 1'b1 || halt_cause !== 2'd2) begin errors++; $display("FAIL bp_halt got halted=%0b cause=%0d want 1/2", halted, halt_cause); end
    btn_step = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (pcen === 1'b1) begin hits++; at = i; end
      if (i == 7) begin
        checks++; if (halted !== 1'b1 || halt_cause !== 2'd3) begin errors++; $display("FAIL step_state got halted=%0b cause=%0d want 1/3", halted, halt_cause); end
      end
      tick();
    end
    checks++; if (hits != 1 || at != 2 + DC) begin errors++; $display("FAIL step_pulse got %0d pulses at %0d want 1 at %0d", hits, at, 2 + DC); end
    btn_step = 0; repeat (8) tick();
    do_reset();
    bp_en = 1; bp_addr = 32'h10; pc = 32'h10; syscall = 1; reg_v0 = 32'd10;
    #1;
    checks++; if (pcen !== 1'b0) begin errors++; $display("FAIL prio_pcen got %0b want 0", pcen); end
    tick(); #1;
    checks++; if (halt_cause !== 2'd1) begin errors++; $display("FAIL prio_cause got %0d want 1", halt_cause); end
  endtask

  task automatic test_display();
    int bad = 0;
    do_reset();
    syscall = 1; reg_v0 = 32'd34; pc = 32'h40;
    #1;
    checks++; if (display_we !== 1'b1 || pcen !== 1'b1) begin errors++; $display("FAIL disp_run got we=%0b pcen=%0b want 1/1", display_we, pcen); end
    tick(); #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL disp_nohalt got %0b want 0", halted); end
    bp_en = 1; bp_addr = 32'h40;
    #1;
    checks++; if (display_we !== 1'b0 || pcen !== 1'b0) begin errors++; $display("FAIL disp_bp got we=%0b pcen=%0b want 0/0", display_we, pcen); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1; if (display_we !== 1'b0 || halted !== 1'b1) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL disp_halted got %0d strobes want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int hits = 0, at = -1;
    btn_go = 1; btn_step = 1;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) bp_en = 0;
      #1;
      if (i <= 6 && pcen === 1'b1) begin hits++; at = i; end
      if (i == 2 + DC) begin
        checks++; if (display_we !== 1'b1) begin errors++; $display("FAIL both_disp got %0b want 1", display_we); end
      end
      if (i == 7) begin
        checks++; if (halted !== 1'b0 || halt_cause !== 2'd0) begin errors++; $display("FAIL both_resume got halted=%0b cause=%0d want 0/0", halted, halt_cause); end
      end
      tick();
    end
    checks++; if (hits != 1 || at != 2 + DC) begin errors++; $display("FAIL both_pulse got %0d pulses at %0d want 1 at %0d", hits, at, 2 + DC); end
    btn_go = 0; btn_step = 0; repeat (8) tick();
  endtask

  task automatic test_async_reset();
    syscall = 1; reg_v0 = 32'd10; bp_en = 0;
    tick(); #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ar_pre got %0b want 1", halted); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || retired_cnt !== '0) begin errors++; $display("FAIL ar_async got halted=%0b cnt=%0d want 0/0", halted, retired_cnt); end
    checks++; if (halt_cause !== 2'd0) begin errors++; $display("FAIL ar_cause got %0d want 0", halt_cause); end
    do_reset();
  endtask

  task automatic test_random();
    bit pe, nh; bit [1:0] nc; bit dwe;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      syscall = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: reg_v0 = 32'd10;
        1: reg_v0 = 32'd34;
        default: reg_v0 = $urandom;
      endcase
      pc      = 32'($urandom_range(0, 7) * 4);
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = 32'($urandom_range(0, 7) * 4);
      if ($urandom_range(0, 5) == 0) btn_go = ~btn_go;
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      #1;
      model_comb(pe, nh, nc);
      dwe = syscall && (reg_v0 == DISP) && pe;
      checks++; if (pcen !== pe) begin errors++; $display("FAIL rnd_pcen cyc %0d got %0b want %0b", n, pcen, pe); end
      checks++; if (display_we !== dwe) begin errors++; $display("FAIL rnd_disp cyc %0d got %0b want %0b", n, display_we, dwe); end
      checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %0b want %0b", n, halted, m_halted); end
      checks++; if (halt_cause !== m_cause) begin errors++; $display("FAIL rnd_cause cyc %0d got %0d want %0d", n, halt_cause, m_cause); end
      checks++; if (retired_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, retired_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_syscall_halt();
    test_go_resume();
    test_bp_step();
    test_display();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
